video_out_fade: RTL and testbench
=================================

# video_out_fade

Palette-lookup video output stage with parametrised DAC width, three pixel-plex modes and a frame-synchronous brightness fade engine. It sits between the renderer pixel mux and the video DAC. It converts 8-bit indexed pixels, through the Z80-writable CRAM (RGB555 + DAC-mode flag), into registered R/G/B outputs. An optional per-frame fade scales all colours toward a programmable brightness level without rewriting CRAM.

## Interface
- OUT_W, 8: DAC bits per channel, legal 5..8.
- CRAM_AW, 8: CRAM address width; 256 entries by default.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- c3  in  1  pixel clock enable; vplex_in is captured only when high.
- tv_blank  in  1  blanking; forces RGB to 0.
- tv_vsync_start  in  1  one-clk strobe per frame; drives the fade engine.
- pix_mode  in  2  0: 8bpp, 1: 4bpp, 2: 2bpp, 3: reserved, treated as 8bpp.
- plex_sel_in  in  2  sub-pixel select within the captured byte.
- palsel  in  CRAM_AW-2  palette page for 4bpp and 2bpp modes.
- cram_data_in  in  16  {mode, R5, G5, B5}.
- cram_addr_in  in  CRAM_AW  CRAM write address.
- cram_we  in  1  CRAM write strobe, one entry per clk.
- vplex_in  in  8  pixel byte from the renderer.
- fade_start  in  1  one-clk pulse; latches fade_target and fade_rate.
- fade_target  in  5  target level 0..16; values above 16 are clamped to 16.
- fade_rate  in  4  frames per level step, minus 1.
- vred, vgrn, vblu  out  OUT_W  registered DAC channels.
- vdac_mode  out  1  registered CRAM bit 15.
- fade_busy  out  1  high while level ≠ target.
- fade_level  out  5  current brightness level, 0..16.

## Operation
- Capture: when c3=1, vplex_in is latched into vplex.
- Index mux (combinational from vplex):
  - 8bpp: vplex.
  - 4bpp: {palsel[CRAM_AW-5:0], plex_sel_in[1] ? vplex[3:0] : vplex[7:4]}.
  - 2bpp: {palsel, dibit}. The dibit is vplex[7:6], [5:4], [3:2] or [1:0] for plex_sel_in = 0, 1, 2, 3.
- CRAM: synchronous dual-port memory.
  - Write port: cram_addr_in, cram_data_in, cram_we.
  - Read port: driven by the index mux, registered output.
  - Read-during-write to the same address returns the old data.
  - Contents are not cleared by rst.
- Scale: each 5-bit channel c becomes s = (c × fade_level) >> 4, 5 bits wide. Level 16 is identity; level 0 is black.
- Expand: output = {s, s[4:10-OUT_W]} for OUT_W > 5, and s for OUT_W = 5.
- Blank: if the aligned blank is high, vred, vgrn and vblu are 0. vdac_mode is never blanked.
- Fade state machine:
  - States: IDLE, WAIT, STEP.
  - fade_start in any state: latch target and rate, clear the frame counter, go to WAIT. If the latched target equals fade_level, go to IDLE instead.
  - WAIT: on each tv_vsync_start, increment the frame counter. When the counter equals the rate, go to STEP.
  - STEP (one clk): move fade_level one unit toward the target and clear the counter. Then go to IDLE if level now equals target, otherwise back to WAIT.
  - fade_busy = (state ≠ IDLE).
  - fade_level changes only in STEP, so brightness only changes at frame start.
- Reset values:
  - vplex = 0, outputs = 0, vdac_mode = 0.
  - fade_level = 16, fade_busy = 0, state IDLE, counter 0.
  - Aligned blank pipeline = 1, so outputs read 0 until the pipeline fills.

## Timing
- Edge E0 (c3=1) captures vplex.
- Edge E1 registers the CRAM read of the index. tv_blank is sampled at E1.
- Edge E2 registers scaled RGB, vdac_mode and the blank gate. Outputs are valid after E2: 2 clk latency from capture.
- plex_sel_in, pix_mode and palsel are sampled at E1, together with the index.
- A CRAM write at edge W is visible to a read whose index is registered at W+1 or later.
- fade_start and tv_vsync_start in the same clk: fade_start wins, and the frame is not counted.
- fade_start pulses back-to-back: the last one wins.
- rst mid-fade: level returns to 16 immediately, with no output glitch beyond the 0 reset value.

## Test plan
- 8bpp lookup, OUT_W=8: CRAM[0x12] = 0x7C1F, vplex_in = 0x12 with c3=1. Two clk later: vred=0xFF, vgrn=0x00, vblu=0xFF, vdac_mode=0.
- 4bpp and 2bpp mux: palsel=0x05, vplex=0xA6.
  - 4bpp, plex_sel_in=2: reads CRAM[0x56].
  - 2bpp, plex_sel_in=1: reads CRAM[0x16].
  - 2bpp, plex_sel_in=3: reads CRAM[0x16]. (palsel is not touched by plex_sel_in in 2bpp.)
- Blank alignment: toggle tv_blank for one clk. Exactly one output sample is 0, aligned per Timing. vdac_mode is unaffected.
- Fade down: fade_target=0, fade_rate=1, fade_start. Level decrements every 2 vsyncs: 16→0 after 32 vsync strobes, then fade_busy falls. CRAM entry R5=31 at level 8 gives vred=0x7B (s=15 → {01111,011}).
- Edge cases:
  - fade_target=20 clamps to 16.
  - fade_start with fade_target equal to the current level: busy stays 0.
  - fade_start coincident with vsync: the frame is not counted.
  - rst mid-fade: level returns to 16.
- Read-during-write: write CRAM[0x40] at the same clk its read is registered. The old value is output. The new value appears from the next pixel.

Source files
------------

// File: rtl/video_out_fade.sv
// video_out_fade: palette-lookup video output stage.
// Pixel byte -> index mux -> CRAM (RGB555 + DAC mode) -> brightness scale
// -> DAC-width expand -> blank gate. Two clocks from capture to output.
// A small frame-synchronous engine walks fade_level toward a target.
module video_out_fade #(
   parameter int OUT_W   = 8,
   parameter int CRAM_AW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               c3,
   input  logic               tv_blank,
   input  logic               tv_vsync_start,
   input  logic [1:0]         pix_mode,
   input  logic [1:0]         plex_sel_in,
   input  logic [CRAM_AW-3:0] palsel,
   input  logic [15:0]        cram_data_in,
   input  logic [CRAM_AW-1:0] cram_addr_in,
   input  logic               cram_we,
   input  logic [7:0]         vplex_in,
   input  logic               fade_start,
   input  logic [4:0]         fade_target,
   input  logic [3:0]         fade_rate,
   output logic [OUT_W-1:0]   vred,
   output logic [OUT_W-1:0]   vgrn,
   output logic [OUT_W-1:0]   vblu,
   output logic               vdac_mode,
   output logic               fade_busy,
   output logic [4:0]         fade_level
);

   typedef enum logic [1:0] {FADE_IDLE, FADE_WAIT, FADE_STEP} fade_state_t;

   logic [7:0]         vplex;
   logic [CRAM_AW-1:0] idx;
   logic [1:0]         dibit;
   logic [15:0]        cram [0:(1<<CRAM_AW)-1];
   logic [15:0]        cram_q;
   logic               blank_q;
   logic [4:0]         r_s, g_s, b_s;
   logic [OUT_W-1:0]   r_x, g_x, b_x;
   fade_state_t        state;
   logic [4:0]         tgt_q;
   logic [4:0]         tgt_clamped;
   logic [3:0]         rate_q;
   logic [3:0]         cnt_q;

   // Channel scale: (c * level) >> 4; level 16 is identity, 0 is black.
   function automatic logic [4:0] scale(input logic [4:0] c, input logic [4:0] lvl);
      logic [9:0] p;
      p = 10'(c) * 10'(lvl);
      return p[8:4];
   endfunction

   // Pixel byte capture on the pixel clock enable.
   always_ff @(posedge clk) begin
      if (rst)     vplex <= 8'd0;
      else if (c3) vplex <= vplex_in;
   end

   // Index mux: 8bpp direct, 4bpp nibble + palette page, 2bpp dibit + page.
   always_comb begin
      idx   = CRAM_AW'(vplex);
      dibit = 2'd0;
      case (plex_sel_in)
         2'd0:    dibit = vplex[7:6];
         2'd1:    dibit = vplex[5:4];
         2'd2:    dibit = vplex[3:2];
         default: dibit = vplex[1:0];
      endcase
      case (pix_mode)
         2'd1:    idx = {palsel[CRAM_AW-5:0], plex_sel_in[1] ? vplex[3:0] : vplex[7:4]};
         2'd2:    idx = {palsel, dibit};
         default: idx = CRAM_AW'(vplex);
      endcase
   end

   // CRAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (cram_we) cram[cram_addr_in] <= cram_data_in;
   end

   // CRAM registered read; a same-edge write is not seen (old data).
   always_ff @(posedge clk) begin
      cram_q <= cram[idx];
   end

   // Blank aligned with the CRAM read stage; resets to blanked.
   always_ff @(posedge clk) begin
      if (rst) blank_q <= 1'b1;
      else     blank_q <= tv_blank;
   end

   assign r_s = scale(cram_q[14:10], fade_level);
   assign g_s = scale(cram_q[9:5],   fade_level);
   assign b_s = scale(cram_q[4:0],   fade_level);

   // Expand 5-bit channels to DAC width by replicating the top bits.
   if (OUT_W > 5) begin : g_expand
      assign r_x = {r_s, r_s[4:10-OUT_W]};
      assign g_x = {g_s, g_s[4:10-OUT_W]};
      assign b_x = {b_s, b_s[4:10-OUT_W]};
   end else begin : g_direct
      assign r_x = r_s;
      assign g_x = g_s;
      assign b_x = b_s;
   end

   // Output register: scaled colour, blank gate, DAC mode (never blanked).
   always_ff @(posedge clk) begin
      if (rst) begin
         vred      <= '0;
         vgrn      <= '0;
         vblu      <= '0;
         vdac_mode <= 1'b0;
      end else begin
         vred      <= blank_q ? '0 : r_x;
         vgrn      <= blank_q ? '0 : g_x;
         vblu      <= blank_q ? '0 : b_x;
         vdac_mode <= cram_q[15];
      end
   end

   assign tgt_clamped = (fade_target > 5'd16) ? 5'd16 : fade_target;

   // Fade engine: fade_start overrides everything (including a same-clk
   // vsync); WAIT counts rate+1 frames, STEP moves the level by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FADE_IDLE;
         fade_level <= 5'd16;
         tgt_q      <= 5'd16;
         rate_q     <= 4'd0;
         cnt_q      <= 4'd0;
      end else if (fade_start) begin
         tgt_q  <= tgt_clamped;
         rate_q <= fade_rate;
         cnt_q  <= 4'd0;
         state  <= (tgt_clamped == fade_level) ? FADE_IDLE : FADE_WAIT;
      end else begin
         case (state)
            FADE_WAIT: begin
               if (tv_vsync_start) begin
                  if (cnt_q == rate_q) state <= FADE_STEP;
                  else                 cnt_q <= cnt_q + 4'd1;
               end
            end
            FADE_STEP: begin
               cnt_q <= 4'd0;
               if (fade_level < tgt_q) begin
                  fade_level <= fade_level + 5'd1;
                  state      <= ((fade_level + 5'd1) == tgt_q) ? FADE_IDLE : FADE_WAIT;
               end else if (fade_level > tgt_q) begin
                  fade_level <= fade_level - 5'd1;
                  state      <= ((fade_level - 5'd1) == tgt_q) ? FADE_IDLE : FADE_WAIT;
               end else begin
                  state <= FADE_IDLE;
               end
            end
            default: state <= FADE_IDLE;
         endcase
      end
   end

   assign fade_busy = (state != FADE_IDLE);

endmodule

// File: tb/tb_video_out_fade.sv
// Directed bench for video_out_fade (OUT_W=8, CRAM_AW=8).
module tb_video_out_fade;
   localparam int OUT_W   = 8;
   localparam int CRAM_AW = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               c3 = 1'b0;
   logic               tv_blank = 1'b0;
   logic               tv_vsync_start = 1'b0;
   logic [1:0]         pix_mode = 2'd0;
   logic [1:0]         plex_sel_in = 2'd0;
   logic [CRAM_AW-3:0] palsel = '0;
   logic [15:0]        cram_data_in = 16'd0;
   logic [CRAM_AW-1:0] cram_addr_in = '0;
   logic               cram_we = 1'b0;
   logic [7:0]         vplex_in = 8'd0;
   logic               fade_start = 1'b0;
   logic [4:0]         fade_target = 5'd0;
   logic [3:0]         fade_rate = 4'd0;
   logic [OUT_W-1:0]   vred, vgrn, vblu;
   logic               vdac_mode, fade_busy;
   logic [4:0]         fade_level;

   int errors = 0;
   int checks = 0;

   video_out_fade #(.OUT_W(OUT_W), .CRAM_AW(CRAM_AW)) dut (
      .clk(clk), .rst(rst), .c3(c3), .tv_blank(tv_blank),
      .tv_vsync_start(tv_vsync_start), .pix_mode(pix_mode),
      .plex_sel_in(plex_sel_in), .palsel(palsel),
      .cram_data_in(cram_data_in), .cram_addr_in(cram_addr_in),
      .cram_we(cram_we), .vplex_in(vplex_in), .fade_start(fade_start),
      .fade_target(fade_target), .fade_rate(fade_rate),
      .vred(vred), .vgrn(vgrn), .vblu(vblu), .vdac_mode(vdac_mode),
      .fade_busy(fade_busy), .fade_level(fade_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_px(input string tag, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic m);
      check({tag, ".r"}, 32'(vred), 32'(r));
      check({tag, ".g"}, 32'(vgrn), 32'(g));
      check({tag, ".b"}, 32'(vblu), 32'(b));
      check({tag, ".m"}, 32'(vdac_mode), 32'(m));
   endtask

   task automatic write_cram(input logic [7:0] a, input logic [15:0] d);
      cram_addr_in = a;
      cram_data_in = d;
      cram_we      = 1'b1;
      tick();
      cram_we      = 1'b0;
   endtask

   // One pixel through the pipe: capture edge, read edge, output edge.
   task automatic pixel(input logic [7:0] b, input logic [1:0] mode, input logic [1:0] sel);
      vplex_in    = b;
      pix_mode    = mode;
      plex_sel_in = sel;
      c3          = 1'b1;
      tick();
      c3          = 1'b0;
      tick();
      tick();
   endtask

   task automatic vsyncs(input int n);
      for (int i = 0; i < n; i++) begin
         tv_vsync_start = 1'b1;
         tick();
         tv_vsync_start = 1'b0;
         tick();
      end
   endtask

   task automatic start_fade(input logic [4:0] t, input logic [3:0] r);
      fade_target = t;
      fade_rate   = r;
      fade_start  = 1'b1;
      tick();
      fade_start  = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check_px("reset", 8'h00, 8'h00, 8'h00, 1'b0);
      check("reset.level", 32'(fade_level), 32'd16);
      check("reset.busy", 32'(fade_busy), 32'd0);
      rst = 1'b0;

      write_cram(8'h12, 16'h7C1F);
      write_cram(8'h56, 16'h8443);
      write_cram(8'h16, 16'h411F);
      write_cram(8'hA6, 16'h03E0);
      write_cram(8'h20, 16'hFFFF);
      write_cram(8'h30, 16'h7C00);
      write_cram(8'h40, 16'h001F);

      // 8bpp lookup
      pixel(8'h12, 2'd0, 2'd0);
      check_px("8bpp_12", 8'hFF, 8'h00, 8'hFF, 1'b0);

      // plex modes
      palsel = 6'h05;
      pixel(8'hA6, 2'd1, 2'd2);
      check_px("4bpp_sel2", 8'h08, 8'h10, 8'h18, 1'b1);
      pixel(8'hA6, 2'd2, 2'd1);
      check_px("2bpp_sel1", 8'h84, 8'h42, 8'hFF, 1'b0);
      pixel(8'hA6, 2'd2, 2'd3);
      check_px("2bpp_sel3", 8'h84, 8'h42, 8'hFF, 1'b0);
      pixel(8'hA6, 2'd0, 2'd3);
      check_px("8bpp_A6", 8'h00, 8'hFF, 8'h00, 1'b0);
      pixel(8'hA6, 2'd3, 2'd1);
      check_px("mode3_A6", 8'h00, 8'hFF, 8'h00, 1'b0);

      // blank alignment: one-clk blank gives exactly one zero sample
      vplex_in = 8'h20; pix_mode = 2'd0; c3 = 1'b1;
      tick(); tick(); tick();
      check_px("blank_pre", 8'hFF, 8'hFF, 8'hFF, 1'b1);
      tv_blank = 1'b1;
      tick();
      check_px("blank_e1", 8'hFF, 8'hFF, 8'hFF, 1'b1);
      tv_blank = 1'b0;
      tick();
      check_px("blank_e2", 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
      check_px("blank_post", 8'hFF, 8'hFF, 8'hFF, 1'b1);

      // read-during-write on the address being read
      vplex_in = 8'h40;
      tick(); tick(); tick();
      check_px("rdw_pre", 8'h00, 8'h00, 8'hFF, 1'b0);
      cram_addr_in = 8'h40; cram_data_in = 16'h7C00; cram_we = 1'b1;
      tick();
      cram_we = 1'b0;
      tick();
      check_px("rdw_old", 8'h00, 8'h00, 8'hFF, 1'b0);
      tick();
      check_px("rdw_new", 8'hFF, 8'h00, 8'h00, 1'b0);

      // fade down, rate 1: one level per 2 vsyncs
      vplex_in = 8'h30;
      tick(); tick(); tick();
      check_px("fade_l16", 8'hFF, 8'h00, 8'h00, 1'b0);
      start_fade(5'd0, 4'd1);
      check("fd.busy0", 32'(fade_busy), 32'd1);
      check("fd.level0", 32'(fade_level), 32'd16);
      vsyncs(1);
      check("fd.level1v", 32'(fade_level), 32'd16);
      vsyncs(15);
      check("fd.level16v", 32'(fade_level), 32'd8);
      tick();
      check_px("fade_l8", 8'h7B, 8'h00, 8'h00, 1'b0);
      vsyncs(15);
      check("fd.level31v", 32'(fade_level), 32'd1);
      check("fd.busy31v", 32'(fade_busy), 32'd1);
      vsyncs(1);
      check("fd.level32v", 32'(fade_level), 32'd0);
      check("fd.busy32v", 32'(fade_busy), 32'd0);
      tick();
      check_px("fade_l0", 8'h00, 8'h00, 8'h00, 1'b0);

      // target equal to current level: stays idle
      start_fade(5'd0, 4'd0);
      check("eq.busy", 32'(fade_busy), 32'd0);
      check("eq.level", 32'(fade_level), 32'd0);

      // target 20 clamps to 16
      start_fade(5'd20, 4'd0);
      check("clamp.busy", 32'(fade_busy), 32'd1);
      vsyncs(16);
      check("clamp.level", 32'(fade_level), 32'd16);
      check("clamp.busy_end", 32'(fade_busy), 32'd0);
      vsyncs(1);
      check("clamp.no_over", 32'(fade_level), 32'd16);

      // back-to-back starts: last one wins (target 12)
      fade_target = 5'd4; fade_rate = 4'd0; fade_start = 1'b1;
      tick();
      fade_target = 5'd12;
      tick();
      fade_start = 1'b0;
      vsyncs(3);
      check("b2b.level3", 32'(fade_level), 32'd13);
      check("b2b.busy3", 32'(fade_busy), 32'd1);
      vsyncs(1);
      check("b2b.level4", 32'(fade_level), 32'd12);
      check("b2b.busy4", 32'(fade_busy), 32'd0);

      // fade_start coincident with vsync: that frame is not counted
      fade_target = 5'd0; fade_rate = 4'd1;
      fade_start = 1'b1; tv_vsync_start = 1'b1;
      tick();
      fade_start = 1'b0; tv_vsync_start = 1'b0;
      vsyncs(1);
      check("coinc.level1", 32'(fade_level), 32'd12);
      vsyncs(1);
      check("coinc.level2", 32'(fade_level), 32'd11);

      // reset mid-fade
      rst = 1'b1;
      tick();
      check("rst.level", 32'(fade_level), 32'd16);
      check("rst.busy", 32'(fade_busy), 32'd0);
      check_px("rst_out", 8'h00, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;

      // CRAM survives reset
      pixel(8'h30, 2'd0, 2'd0);
      check_px("post_rst", 8'hFF, 8'h00, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
